// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//
// Shared types and helpers for the SDRAM memory-port arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY)
//   idx_width() : bit width needed to hold a port index for a given port
//                 count (never less than 1, so a single-bit index still
//                 exists for degenerate configurations)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int nports);
        return (nports > 1) ? $clog2(nports) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles the per-port requester streams and the single downstream
// command/data streams of the memory-port arbiter.
//
// Handshake rule for every stream in this bundle: a transfer happens on a
// rising clock edge where valid and ready are both high. Once valid is
// raised the sender holds it, together with the payload (we, address,
// data, byte selects), stable until that transfer edge. Ready may be
// raised or dropped freely and may depend combinationally on valid.
//
// Signals (widths follow NPORTS, AW, DW):
//   s_we_i, s_adr_i, s_cmd_valid_i, s_cmd_ready_o   per-port command
//   s_data_i, s_sel_i, s_data_valid_i, s_data_ready_o per-port write data
//   m_we_o, m_adr_o, m_cmd_valid_o, m_cmd_ready_i    command downstream
//   m_data_o, m_sel_o, m_data_valid_o, m_data_ready_i data downstream
//
// Modports:
//   master : the arbiter itself (drives the downstream streams and the
//            per-port readies)
//   slave  : the surrounding environment (requesters plus downsizer)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int NPORTS = 2,
    parameter int AW     = 32,
    parameter int DW     = 32
) ();

    // Per-port requester side
    logic [NPORTS-1:0]          s_we_i;
    logic [NPORTS*AW-1:0]       s_adr_i;
    logic [NPORTS-1:0]          s_cmd_valid_i;
    logic [NPORTS-1:0]          s_cmd_ready_o;
    logic [NPORTS*DW-1:0]       s_data_i;
    logic [NPORTS*(DW/8)-1:0]   s_sel_i;
    logic [NPORTS-1:0]          s_data_valid_i;
    logic [NPORTS-1:0]          s_data_ready_o;

    // Downstream side toward the write downsizer
    logic                       m_we_o;
    logic [AW-1:0]              m_adr_o;
    logic                       m_cmd_valid_o;
    logic                       m_cmd_ready_i;
    logic [DW-1:0]              m_data_o;
    logic [DW/8-1:0]            m_sel_o;
    logic                       m_data_valid_o;
    logic                       m_data_ready_i;

    modport master (
        input  s_we_i, s_adr_i, s_cmd_valid_i,
        input  s_data_i, s_sel_i, s_data_valid_i,
        output s_cmd_ready_o, s_data_ready_o,
        output m_we_o, m_adr_o, m_cmd_valid_o,
        output m_data_o, m_sel_o, m_data_valid_o,
        input  m_cmd_ready_i, m_data_ready_i
    );

    modport slave (
        output s_we_i, s_adr_i, s_cmd_valid_i,
        output s_data_i, s_sel_i, s_data_valid_i,
        input  s_cmd_ready_o, s_data_ready_o,
        input  m_we_o, m_adr_o, m_cmd_valid_o,
        input  m_data_o, m_sel_o, m_data_valid_o,
        output m_cmd_ready_i, m_data_ready_i
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// mem_rr_pick
//
// Combinational winner picker. Scans the request vector starting at
// start_i and wrapping around; the first requesting port found wins.
// Tying start_i to zero turns it into a fixed lowest-index-wins picker.
//
// Ports:
//   req_i     [N]   request vector, port p at bit p
//   start_i   [IW]  first port index to examine (expected < N)
//   gnt_idx_o [IW]  index of the winning port (0 when nothing found)
//   found_o         at least one request was present
// ---------------------------------------------------------------------------
module mem_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [IW-1:0] gnt_idx_o,
    output logic          found_o
);

    always_comb begin
        int idx;
        idx       = 0;
        gnt_idx_o = '0;
        found_o   = 1'b0;
        for (int off = 0; off < N; off++) begin
            // Modulo keeps the scan inside the port range even if start_i
            // carries an out-of-range code for non-power-of-two N.
            idx = (int'(start_i) + off) % N;
            if (!found_o && req_i[idx]) begin
                found_o   = 1'b1;
                gnt_idx_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one SDRAM command stream and its paired write-data stream among
// NPORTS requesters. A transaction is one command (we, address) plus, for
// writes, exactly one DW-wide data word with byte selects. One port is
// granted at a time and keeps the grant until its whole transaction has
// been handed downstream; reads never forward data.
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                          undefined -> round-robin, search starts after
//                                       the previously released port
//
// Ports:
//   clk              clock, all logic on the rising edge
//   rst              synchronous, active-high reset
//   bus              mem_port_arbiter_if.master (requester + downstream)
//   dbg_state_o      current FSM state
//   dbg_grant_o      grant index register (meaningful in BUSY)
//   dbg_last_grant_o last released port index
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    mem_port_arbiter_if.master           bus,
    output arb_state_t                   dbg_state_o,
    output logic [idx_width(NPORTS)-1:0] dbg_grant_o,
    output logic [idx_width(NPORTS)-1:0] dbg_last_grant_o
);

    localparam int IW = idx_width(NPORTS);
    localparam int SW = DW / 8;

    // State registers
    arb_state_t    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q,  last_d;
    logic          cmd_done_q,  cmd_done_d;
    logic          data_done_q, data_done_d;

    // Downstream / ready signals before they reach the interface
    logic              m_we;
    logic [AW-1:0]     m_adr;
    logic              m_cmd_valid;
    logic [DW-1:0]     m_data;
    logic [SW-1:0]     m_sel;
    logic              m_data_valid;
    logic [NPORTS-1:0] s_cmd_ready;
    logic [NPORTS-1:0] s_data_ready;

    logic cmd_hs;
    logic data_hs;

    // Winner selection
    logic [IW-1:0] start_idx;
    logic [IW-1:0] pick_idx;
    logic          pick_found;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign start_idx = '0;
`else
    // Reset leaves last_q at the top port so the first search starts at 0.
    assign start_idx = (last_q == IW'(NPORTS - 1)) ? '0 : last_q + 1'b1;
`endif

    mem_rr_pick #(
        .N  (NPORTS),
        .IW (IW)
    ) u_pick (
        .req_i     (bus.s_cmd_valid_i),
        .start_i   (start_idx),
        .gnt_idx_o (pick_idx),
        .found_o   (pick_found)
    );

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= IW'(NPORTS - 1);
            cmd_done_q  <= 1'b0;
            data_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cmd_done_q  <= cmd_done_d;
            data_done_q <= data_done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cmd_done_d  = cmd_done_q;
        data_done_d = data_done_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d     = pick_idx;
                    cmd_done_d  = 1'b0;
                    data_done_d = 1'b0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                // The two halves of a write may complete in either order or
                // on the same edge; the sticky flags fold in this cycle's
                // handshake so release happens on whichever edge is last.
                cmd_done_d  = cmd_done_q  | cmd_hs;
                data_done_d = data_done_q | data_hs;
                if (cmd_done_d && (!m_we || data_done_d)) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic: the granted port is muxed through only in BUSY, so
    // everything reads zero while idle or in reset.
    // -----------------------------------------------------------------------
    always_comb begin
        m_we         = 1'b0;
        m_adr        = '0;
        m_cmd_valid  = 1'b0;
        m_data       = '0;
        m_sel        = '0;
        m_data_valid = 1'b0;
        s_cmd_ready  = '0;
        s_data_ready = '0;
        if (state_q == BUSY) begin
            for (int p = 0; p < NPORTS; p++) begin
                if (grant_q == IW'(p)) begin
                    m_we           = bus.s_we_i[p];
                    m_adr          = bus.s_adr_i[p*AW +: AW];
                    m_cmd_valid    = bus.s_cmd_valid_i[p] & ~cmd_done_q;
                    s_cmd_ready[p] = bus.m_cmd_ready_i & ~cmd_done_q;
                    if (bus.s_we_i[p]) begin
                        m_data          = bus.s_data_i[p*DW +: DW];
                        m_sel           = bus.s_sel_i[p*SW +: SW];
                        m_data_valid    = bus.s_data_valid_i[p] & ~data_done_q;
                        s_data_ready[p] = bus.m_data_ready_i & ~data_done_q;
                    end
                end
            end
        end
    end

    assign cmd_hs  = m_cmd_valid  & bus.m_cmd_ready_i;
    assign data_hs = m_data_valid & bus.m_data_ready_i;

    assign bus.m_we_o         = m_we;
    assign bus.m_adr_o        = m_adr;
    assign bus.m_cmd_valid_o  = m_cmd_valid;
    assign bus.m_data_o       = m_data;
    assign bus.m_sel_o        = m_sel;
    assign bus.m_data_valid_o = m_data_valid;
    assign bus.s_cmd_ready_o  = s_cmd_ready;
    assign bus.s_data_ready_o = s_data_ready;

    assign dbg_state_o      = state_q;
    assign dbg_grant_o      = grant_q;
    assign dbg_last_grant_o = last_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter with three ports. Requesters are modelled by
// per-port registers that drop valid after their handshake and can reissue
// follow-up transactions. Expected downstream commands and write words are
// queued when a scenario is set up and checked in order as the arbiter
// hands them downstream. Honours MEM_ARB_FIXED_PRIO_EN for the grant order.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int NP  = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int IW  = idx_width(NP);
    localparam int CW  = 1 + AW;
    localparam int DXW = DW + SW;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.NPORTS(NP), .AW(AW), .DW(DW)) bus ();

    arb_state_t    dbg_state;
    logic [IW-1:0] dbg_grant;
    logic [IW-1:0] dbg_last;

    mem_port_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .dbg_state_o      (dbg_state),
        .dbg_grant_o      (dbg_grant),
        .dbg_last_grant_o (dbg_last)
    );

    // Requester models and downstream readiness
    logic [NP-1:0] r_cmd_v, r_data_v, r_we, cmd_f, data_f, cmd_ack, data_ack;
    logic [AW-1:0] r_adr [NP];
    logic [DW-1:0] r_dat [NP];
    logic [SW-1:0] r_sel [NP];
    int            r_left [NP];
    logic          rst_v, dn_cmd_rdy, dn_data_rdy;

    // Scoreboard
    logic [CW-1:0]  exp_cmd_q [$];
    logic [DXW-1:0] exp_data_q [$];
    int             hs_cyc_q [$];
    int cyc, n_cmd_hs, n_data_hs;
    int compared, mismatched;

    // One clock: update/drive at posedge+1, observe at the following negedge.
    task automatic step();
        logic [CW-1:0]  ce;
        logic [DXW-1:0] de;
        @(posedge clk);
        #1;
        rst = rst_v;
        for (int p = 0; p < NP; p++) begin
            if (cmd_ack[p]) begin r_cmd_v[p] = 1'b0; cmd_f[p] = 1'b1; end
            if (data_ack[p]) begin r_data_v[p] = 1'b0; data_f[p] = 1'b1; end
            if (cmd_f[p] && (!r_we[p] || data_f[p])) begin
                cmd_f[p]  = 1'b0;
                data_f[p] = 1'b0;
                if (r_left[p] > 0) begin
                    r_left[p]   = r_left[p] - 1;
                    r_adr[p]    = r_adr[p] + 32'd4;
                    r_dat[p]    = r_dat[p] + 32'd1;
                    r_cmd_v[p]  = 1'b1;
                    r_data_v[p] = r_we[p];
                end
            end
        end
        cmd_ack  = '0;
        data_ack = '0;
        bus.s_cmd_valid_i  = r_cmd_v;
        bus.s_data_valid_i = r_data_v;
        bus.s_we_i         = r_we;
        for (int p = 0; p < NP; p++) begin
            bus.s_adr_i[p*AW +: AW]  = r_adr[p];
            bus.s_data_i[p*DW +: DW] = r_dat[p];
            bus.s_sel_i[p*SW +: SW]  = r_sel[p];
        end
        bus.m_cmd_ready_i  = dn_cmd_rdy;
        bus.m_data_ready_i = dn_data_rdy;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (bus.m_cmd_valid_o && bus.m_cmd_ready_i) begin
                n_cmd_hs++;
                hs_cyc_q.push_back(cyc);
                compared++;
                if (exp_cmd_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL cmd_unexpected: got we=%0b adr=%h, none queued", bus.m_we_o, bus.m_adr_o);
                end else begin
                    ce = exp_cmd_q.pop_front();
                    if ({bus.m_we_o, bus.m_adr_o} !== ce) begin
                        mismatched++;
                        $display("FAIL cmd_order: got we/adr %h, expected %h", {bus.m_we_o, bus.m_adr_o}, ce);
                    end
                end
            end
            if (bus.m_data_valid_o && bus.m_data_ready_i) begin
                n_data_hs++;
                compared++;
                if (exp_data_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL data_unexpected: got data=%h sel=%h, none queued", bus.m_data_o, bus.m_sel_o);
                end else begin
                    de = exp_data_q.pop_front();
                    if ({bus.m_data_o, bus.m_sel_o} !== de) begin
                        mismatched++;
                        $display("FAIL data_order: got data/sel %h, expected %h", {bus.m_data_o, bus.m_sel_o}, de);
                    end
                end
            end
            cmd_ack  = bus.s_cmd_valid_i & bus.s_cmd_ready_o;
            data_ack = bus.s_data_valid_i & bus.s_data_ready_o;
        end
    endtask

    // Driver: load a transaction into one requester model.
    task automatic req(input int p, input logic we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat, input logic [SW-1:0] sel, input int reissue);
        r_we[p]     = we;
        r_adr[p]    = adr;
        r_dat[p]    = dat;
        r_sel[p]    = sel;
        r_left[p]   = reissue;
        r_cmd_v[p]  = 1'b1;
        r_data_v[p] = we;
        cmd_f[p]    = 1'b0;
        data_f[p]   = 1'b0;
    endtask

    task automatic test_reset();
        rst_v = 1'b1; dn_cmd_rdy = 1'b1; dn_data_rdy = 1'b1;
        repeat (3) step();
        compared++;
        if ({bus.m_cmd_valid_o, bus.m_data_valid_o, bus.m_we_o} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_valids: got %b, expected 000", {bus.m_cmd_valid_o, bus.m_data_valid_o, bus.m_we_o});
        end
        compared++;
        if ({bus.s_cmd_ready_o, bus.s_data_ready_o} !== '0) begin
            mismatched++;
            $display("FAIL reset_readies: got %b, expected 0", {bus.s_cmd_ready_o, bus.s_data_ready_o});
        end
        compared++;
        if ({bus.m_adr_o, bus.m_data_o, bus.m_sel_o} !== '0) begin
            mismatched++;
            $display("FAIL reset_bus: got adr=%h data=%h sel=%h, expected 0", bus.m_adr_o, bus.m_data_o, bus.m_sel_o);
        end
        rst_v = 1'b0;
        step();
        compared++;
        if (dbg_state !== IDLE) begin
            mismatched++;
            $display("FAIL reset_state: got %0d, expected IDLE", dbg_state);
        end
    endtask

    task automatic test_single_write();
        exp_cmd_q.push_back({1'b1, 32'h0000_0100});
        exp_data_q.push_back({32'hDEAD_BEEF, 4'hF});
        req(1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 0);
        step();
        compared++;
        if ({bus.m_cmd_valid_o, bus.m_we_o, bus.m_adr_o, bus.s_cmd_ready_o} !== '0) begin
            mismatched++;
            $display("FAIL sw_idle_quiet: got cv=%b we=%b adr=%h rdy=%b, expected all 0",
                     bus.m_cmd_valid_o, bus.m_we_o, bus.m_adr_o, bus.s_cmd_ready_o);
        end
        step();
        compared++;
        if ({bus.m_cmd_valid_o, bus.m_data_valid_o} !== 2'b11) begin
            mismatched++;
            $display("FAIL sw_valids: got %b, expected 11", {bus.m_cmd_valid_o, bus.m_data_valid_o});
        end
        compared++;
        if ({bus.s_cmd_ready_o, bus.s_data_ready_o} !== {3'b010, 3'b010}) begin
            mismatched++;
            $display("FAIL sw_readies: got cmd=%b data=%b, expected 010 010", bus.s_cmd_ready_o, bus.s_data_ready_o);
        end
        compared++;
        if (dbg_grant !== 2'd1) begin
            mismatched++;
            $display("FAIL sw_grant: got %0d, expected 1", dbg_grant);
        end
        step();
        compared++;
        if ({dbg_state, bus.m_cmd_valid_o, bus.m_data_valid_o, bus.s_cmd_ready_o, bus.s_data_ready_o} !== '0) begin
            mismatched++;
            $display("FAIL sw_release: got state=%0d cv=%b dv=%b cr=%b dr=%b, expected IDLE and 0",
                     dbg_state, bus.m_cmd_valid_o, bus.m_data_valid_o, bus.s_cmd_ready_o, bus.s_data_ready_o);
        end
        compared++;
        if (dbg_last !== 2'd1) begin
            mismatched++;
            $display("FAIL sw_last_grant: got %0d, expected 1", dbg_last);
        end
    endtask

    task automatic test_rr_reads();
        int base;
        base = n_cmd_hs;
        hs_cyc_q.delete();
        exp_cmd_q.push_back({1'b0, 32'h0000_0200});
        exp_cmd_q.push_back({1'b0, 32'h0000_0300});
        exp_cmd_q.push_back({1'b0, 32'h0000_0204});
        exp_cmd_q.push_back({1'b0, 32'h0000_0304});
        req(0, 1'b0, 32'h0000_0200, '0, '0, 1);
        req(1, 1'b0, 32'h0000_0300, '0, '0, 1);
        for (int i = 0; i < 30 && n_cmd_hs < base + 4; i++) step();
        compared++;
        if (n_cmd_hs !== base + 4) begin
            mismatched++;
            $display("FAIL rr_timeout: got %0d grants, expected 4", n_cmd_hs - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                compared++;
                if (hs_cyc_q[i+1] - hs_cyc_q[i] !== 2) begin
                    mismatched++;
                    $display("FAIL rr_spacing: got %0d cycles, expected 2", hs_cyc_q[i+1] - hs_cyc_q[i]);
                end
            end
        end
        step();
    endtask

    task automatic test_data_stall();
        exp_cmd_q.push_back({1'b1, 32'h0000_0400});
        exp_data_q.push_back({32'h1234_5678, 4'h3});
        dn_data_rdy = 1'b0;
        req(2, 1'b1, 32'h0000_0400, 32'h1234_5678, 4'h3, 0);
        step();
        step();
        compared++;
        if ({bus.m_cmd_valid_o, bus.m_data_valid_o} !== 2'b11) begin
            mismatched++;
            $display("FAIL ds_valids: got %b, expected 11", {bus.m_cmd_valid_o, bus.m_data_valid_o});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            compared++;
            if ({dbg_state, bus.m_cmd_valid_o, bus.s_cmd_ready_o, bus.m_data_valid_o, bus.s_data_ready_o}
                !== {BUSY, 1'b0, 3'b000, 1'b1, 3'b000}) begin
                mismatched++;
                $display("FAIL ds_hold: got state=%0d cv=%b cr=%b dv=%b dr=%b, expected BUSY 0 000 1 000",
                         dbg_state, bus.m_cmd_valid_o, bus.s_cmd_ready_o, bus.m_data_valid_o, bus.s_data_ready_o);
            end
        end
        dn_data_rdy = 1'b1;
        step();
        compared++;
        if (bus.s_data_ready_o !== 3'b100) begin
            mismatched++;
            $display("FAIL ds_data_ready: got %b, expected 100", bus.s_data_ready_o);
        end
        step();
        compared++;
        if ({dbg_state, bus.m_data_valid_o} !== {IDLE, 1'b0}) begin
            mismatched++;
            $display("FAIL ds_release: got state=%0d dv=%b, expected IDLE 0", dbg_state, bus.m_data_valid_o);
        end
    endtask

    task automatic test_cmd_late();
        exp_cmd_q.push_back({1'b1, 32'h0000_0500});
        exp_data_q.push_back({32'hCAFE_F00D, 4'hC});
        dn_cmd_rdy = 1'b0;
        req(0, 1'b1, 32'h0000_0500, 32'hCAFE_F00D, 4'hC, 0);
        step();
        step();
        compared++;
        if ({bus.m_cmd_valid_o, bus.m_data_valid_o, bus.s_data_ready_o} !== {2'b11, 3'b001}) begin
            mismatched++;
            $display("FAIL cl_first: got cv=%b dv=%b dr=%b, expected 1 1 001",
                     bus.m_cmd_valid_o, bus.m_data_valid_o, bus.s_data_ready_o);
        end
        step();
        compared++;
        if ({dbg_state, bus.m_cmd_valid_o, bus.m_data_valid_o, bus.s_data_ready_o, bus.s_cmd_ready_o}
            !== {BUSY, 1'b1, 1'b0, 3'b000, 3'b000}) begin
            mismatched++;
            $display("FAIL cl_wait: got state=%0d cv=%b dv=%b dr=%b cr=%b, expected BUSY 1 0 000 000",
                     dbg_state, bus.m_cmd_valid_o, bus.m_data_valid_o, bus.s_data_ready_o, bus.s_cmd_ready_o);
        end
        dn_cmd_rdy = 1'b1;
        step();
        compared++;
        if (bus.s_cmd_ready_o !== 3'b001) begin
            mismatched++;
            $display("FAIL cl_cmd_ready: got %b, expected 001", bus.s_cmd_ready_o);
        end
        step();
        compared++;
        if (dbg_state !== IDLE) begin
            mismatched++;
            $display("FAIL cl_release: got %0d, expected IDLE", dbg_state);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        dn_cmd_rdy = 1'b0;
        req(1, 1'b0, 32'h0000_0600, '0, '0, 0);
        step();
        step();
        compared++;
        if ({dbg_state, bus.m_cmd_valid_o} !== {BUSY, 1'b1}) begin
            mismatched++;
            $display("FAIL rm_pending: got state=%0d cv=%b, expected BUSY 1", dbg_state, bus.m_cmd_valid_o);
        end
        rst_v = 1'b1;
        step();
        step();
        compared++;
        if ({dbg_state, bus.m_cmd_valid_o, bus.m_we_o, bus.m_adr_o, bus.s_cmd_ready_o, bus.m_data_valid_o} !== '0) begin
            mismatched++;
            $display("FAIL rm_outputs: got state=%0d cv=%b we=%b adr=%h cr=%b dv=%b, expected all 0",
                     dbg_state, bus.m_cmd_valid_o, bus.m_we_o, bus.m_adr_o, bus.s_cmd_ready_o, bus.m_data_valid_o);
        end
        // Port 1 is still holding its request; port 0 joins. Reset must
        // restart the search at port 0.
        base = n_cmd_hs;
        exp_cmd_q.push_back({1'b0, 32'h0000_0700});
        exp_cmd_q.push_back({1'b0, 32'h0000_0600});
        req(0, 1'b0, 32'h0000_0700, '0, '0, 0);
        rst_v = 1'b0;
        dn_cmd_rdy = 1'b1;
        for (int i = 0; i < 20 && n_cmd_hs < base + 2; i++) step();
        compared++;
        if (n_cmd_hs !== base + 2) begin
            mismatched++;
            $display("FAIL rm_timeout: got %0d grants, expected 2", n_cmd_hs - base);
        end
        step();
    endtask

    task automatic test_ports_0_2();
        int base;
        rst_v = 1'b1;
        step();
        step();
        rst_v = 1'b0;
        base = n_cmd_hs;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 3; k++) exp_cmd_q.push_back({1'b0, 32'h0000_0800 + 32'(4 * k)});
        for (int k = 0; k < 3; k++) exp_cmd_q.push_back({1'b0, 32'h0000_0A00 + 32'(4 * k)});
`else
        for (int k = 0; k < 3; k++) begin
            exp_cmd_q.push_back({1'b0, 32'h0000_0800 + 32'(4 * k)});
            exp_cmd_q.push_back({1'b0, 32'h0000_0A00 + 32'(4 * k)});
        end
`endif
        req(0, 1'b0, 32'h0000_0800, '0, '0, 2);
        req(2, 1'b0, 32'h0000_0A00, '0, '0, 2);
        for (int i = 0; i < 40 && n_cmd_hs < base + 6; i++) step();
        compared++;
        if (n_cmd_hs !== base + 6) begin
            mismatched++;
            $display("FAIL p02_timeout: got %0d grants, expected 6", n_cmd_hs - base);
        end
        step();
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int            p;
            logic          we;
            logic [AW-1:0] adr;
            logic [DW-1:0] dat;
            logic [SW-1:0] sel;
            int            i;
            p   = $urandom_range(0, NP - 1);
            we  = 1'($urandom_range(0, 1));
            adr = $urandom & 32'hFFFF_FFFC;
            dat = $urandom;
            sel = 4'($urandom_range(1, 15));
            exp_cmd_q.push_back({we, adr});
            if (we) exp_data_q.push_back({dat, sel});
            req(p, we, adr, dat, sel, 0);
            for (i = 0; i < 60 && (r_cmd_v[p] || r_data_v[p]); i++) begin
                dn_cmd_rdy  = 1'($urandom_range(0, 1));
                dn_data_rdy = 1'($urandom_range(0, 1));
                step();
            end
            compared++;
            if (r_cmd_v[p] || r_data_v[p]) begin
                mismatched++;
                $display("FAIL rnd_timeout: txn %0d port %0d still pending after %0d cycles", t, p, i);
            end
        end
        dn_cmd_rdy  = 1'b1;
        dn_data_rdy = 1'b1;
        step();
    endtask

    initial begin
        compared = 0; mismatched = 0; cyc = 0; n_cmd_hs = 0; n_data_hs = 0;
        r_cmd_v = '0; r_data_v = '0; r_we = '0; cmd_f = '0; data_f = '0;
        cmd_ack = '0; data_ack = '0;
        for (int p = 0; p < NP; p++) begin
            r_adr[p] = '0; r_dat[p] = '0; r_sel[p] = '0; r_left[p] = 0;
        end
        rst_v = 1'b1; dn_cmd_rdy = 1'b0; dn_data_rdy = 1'b0;
        bus.s_we_i = '0; bus.s_adr_i = '0; bus.s_cmd_valid_i = '0;
        bus.s_data_i = '0; bus.s_sel_i = '0; bus.s_data_valid_i = '0;
        bus.m_cmd_ready_i = 1'b0; bus.m_data_ready_i = 1'b0;

        test_reset();
        test_single_write();
        test_rr_reads();
        test_data_stall();
        test_cmd_late();
        test_reset_mid();
        test_ports_0_2();
        test_random();

        compared++;
        if (exp_cmd_q.size() != 0 || exp_data_q.size() != 0) begin
            mismatched++;
            $display("FAIL leftover: got %0d cmd / %0d data still queued, expected 0 / 0",
                     exp_cmd_q.size(), exp_data_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
